lcd_refresh_ctrl: RTL

Sequencer and owner of the character-LCD bus (HD44780-style, 8-bit, 2×16) for the calculator. After reset it runs the power-up delay and the init command set. It then continuously repaints both lines from an internal 32-character buffer. Calculator logic writes characters into that buffer through a simple write port and never drives the LCD pins directly.

---
 rtl/lcd_refresh_if.sv | 36 +++
 rtl/lcd_refresh_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_if.sv
// Bus between the calculator logic and the LCD refresh controller.
// The controller also owns the LCD pins, which are carried here so the
// whole block connects through one port.
interface lcd_refresh_if;
    // Write port semantics: there is no valid/ready pairing. Any strobe
    // (wr_en, clr_req, reinit) is accepted in every cycle it is high and is
    // never back-pressured. clr_req beats wr_en in the same cycle.
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr_req;
    logic       reinit;

    // LCD pins and status, all registered inside the controller.
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       ready;
    logic       frame_done;

    // Current sequencer state, for observation only.
    logic [3:0] fsm_state;

    // Calculator side.
    modport master (
        output wr_en, wr_addr, wr_data, clr_req, reinit,
        input  lcd_e, lcd_rs, lcd_rw, lcd_data, ready, frame_done, fsm_state
    );

    // Controller side.
    modport slave (
        input  wr_en, wr_addr, wr_data, clr_req, reinit,
        output lcd_e, lcd_rs, lcd_rw, lcd_data, ready, frame_done, fsm_state
    );
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// HD44780-style 8-bit LCD sequencer: power-up delay, init command set,
// then endless repaint of a 32-character buffer (2 lines x 16 columns).
// Time is divided into slots of 2*TICK_DIV cycles; a transaction slot
// holds rs/rw/data for the whole slot and raises lcd_e for the first half.
module lcd_refresh_ctrl #(
    parameter int TICK_DIV  = 5,
    parameter int PWR_SLOTS = 35,
    parameter int CLR_SLOTS = 100,
    parameter int GAP_SLOTS = 200
) (
    input  logic         clk,
    input  logic         rst,
    lcd_refresh_if.slave bus
);
    localparam int SLOT_LEN = 2 * TICK_DIV;
    localparam int CYC_W    = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int MAX_A    = (PWR_SLOTS > CLR_SLOTS) ? PWR_SLOTS : CLR_SLOTS;
    localparam int MAX_B    = (MAX_A > GAP_SLOTS) ? MAX_A : GAP_SLOTS;
    localparam int MAX_C    = (MAX_B > 17) ? MAX_B : 17;
    localparam int CNT_W    = $clog2(MAX_C + 1);

    localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(SLOT_LEN - 1);
    localparam logic [CYC_W-1:0] HALF_CYC  = CYC_W'(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST_PWR  = CNT_W'(PWR_SLOTS - 1);
    localparam logic [CNT_W-1:0] LAST_CLR  = CNT_W'(CLR_SLOTS - 1);
    localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(GAP_SLOTS - 1);
    // In a line, slot 0 is the address command and slots 1..16 are characters.
    localparam logic [CNT_W-1:0] LAST_CHAR = CNT_W'(16);

    typedef enum logic [3:0] {
        PWR_WAIT = 4'd0,
        FUNC_SET = 4'd1,
        DISP_ON  = 4'd2,
        ENTRY    = 4'd3,
        CLEAR    = 4'd4,
        CLR_WAIT = 4'd5,
        LINE1    = 4'd6,
        LINE2    = 4'd7,
        GAP      = 4'd8
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] slot, slot_n;
    logic [CYC_W-1:0] cyc, cyc_n;
    logic             pending, pending_n;
    logic             slot_end;

    logic             e_q, e_n;
    logic             rs_q, rs_n;
    logic             rw_q, rw_n;
    logic [7:0]       data_q, data_n;
    logic             ready_q, ready_n;
    logic             done_q, done_n;
    logic [4:0]       rd_idx;

    logic [7:0]       char_buf [32];

    assign slot_end = (cyc == LAST_CYC);

    // Character buffer: reset and clr_req fill with spaces; clr_req drops a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst || bus.clr_req) begin
            for (int i = 0; i < 32; i++) begin
                char_buf[i] <= 8'h20;
            end
        end else if (bus.wr_en) begin
            char_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Next-state and next-output logic; outputs are computed for the upcoming cycle.
    always_comb begin
        state_n   = state;
        slot_n    = slot;
        cyc_n     = cyc + CYC_W'(1);
        pending_n = pending | bus.reinit;
        rs_n      = rs_q;
        rw_n      = rw_q;
        data_n    = data_q;
        rd_idx    = 5'd0;

        if (slot_end) begin
            cyc_n     = '0;
            pending_n = 1'b0;
            slot_n    = slot + CNT_W'(1);
            if (pending || bus.reinit) begin
                // A reinit only ever lands on a slot boundary, so lcd_e is never cut short.
                state_n = FUNC_SET;
                slot_n  = '0;
            end else begin
                case (state)
                    PWR_WAIT: if (slot == LAST_PWR) begin
                        state_n = FUNC_SET;
                        slot_n  = '0;
                    end
                    FUNC_SET: begin
                        state_n = DISP_ON;
                        slot_n  = '0;
                    end
                    DISP_ON: begin
                        state_n = ENTRY;
                        slot_n  = '0;
                    end
                    ENTRY: begin
                        state_n = CLEAR;
                        slot_n  = '0;
                    end
                    CLEAR: begin
                        state_n = CLR_WAIT;
                        slot_n  = '0;
                    end
                    CLR_WAIT: if (slot == LAST_CLR) begin
                        state_n = LINE1;
                        slot_n  = '0;
                    end
                    LINE1: if (slot == LAST_CHAR) begin
                        state_n = LINE2;
                        slot_n  = '0;
                    end
                    LINE2: if (slot == LAST_CHAR) begin
                        state_n = GAP;
                        slot_n  = '0;
                    end
                    GAP: if (slot == LAST_GAP) begin
                        state_n = LINE1;
                        slot_n  = '0;
                    end
                    default: begin
                        state_n = PWR_WAIT;
                        slot_n  = '0;
                    end
                endcase
            end
        end

        // rs/rw/data are loaded on the edge that opens a slot and held for the
        // whole slot, so a buffer write during the slot cannot change the bus.
        if (cyc_n == '0) begin
            rs_n   = 1'b0;
            rw_n   = 1'b0;
            rd_idx = {(state_n == LINE2), slot_n[3:0] - 4'd1};
            case (state_n)
                FUNC_SET: data_n = 8'h3C;
                DISP_ON:  data_n = 8'h0C;
                ENTRY:    data_n = 8'h06;
                CLEAR:    data_n = 8'h01;
                LINE1, LINE2: begin
                    if (slot_n == '0) begin
                        data_n = (state_n == LINE1) ? 8'h80 : 8'hC0;
                    end else begin
                        rs_n   = 1'b1;
                        data_n = char_buf[rd_idx];
                    end
                end
                default: begin
                    rw_n   = 1'b1;
                    data_n = 8'h00;
                end
            endcase
        end

        e_n     = !(state_n inside {PWR_WAIT, CLR_WAIT, GAP}) && (cyc_n < HALF_CYC);
        ready_n = state_n inside {LINE1, LINE2, GAP};
        done_n  = (state_n == LINE2) && (slot_n == LAST_CHAR) && (cyc_n == LAST_CYC);
    end

    // State, counters and registered LCD outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PWR_WAIT;
            slot    <= '0;
            cyc     <= '0;
            pending <= 1'b0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b1;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            slot    <= slot_n;
            cyc     <= cyc_n;
            pending <= pending_n;
            e_q     <= e_n;
            rs_q    <= rs_n;
            rw_q    <= rw_n;
            data_q  <= data_n;
            ready_q <= ready_n;
            done_q  <= done_n;
        end
    end

    assign bus.lcd_e      = e_q;
    assign bus.lcd_rs     = rs_q;
    assign bus.lcd_rw     = rw_q;
    assign bus.lcd_data   = data_q;
    assign bus.ready      = ready_q;
    assign bus.frame_done = done_q;
    assign bus.fsm_state  = state;
endmodule
